// File: rtl/lbp_stream_extractor.sv
// Streaming multi-channel local-binary-pattern extractor.
// Each channel keeps its own sliding window (last sample, partial pattern,
// fill count) in a per-channel slot; the top muxes the addressed slot into a
// single valid/ready output register.

// Per-channel window state and next-pattern computation.
module lbp_ch_slot #(
   parameter int SAMPLE_SIZE = 16,
   parameter int LBP_SIZE    = 6,
   parameter bit SIGNED      = 1'b0,
   parameter int FILL_W      = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   we_i,
   input  logic [SAMPLE_SIZE-1:0] sample_i,
   output logic [LBP_SIZE-1:0]    pattern_o,
   output logic                   emit_o
);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LBP_SIZE + 1);

   logic [SAMPLE_SIZE-1:0] last_q, last_d;
   logic [LBP_SIZE-2:0]    hist_q, hist_d;
   logic [FILL_W-1:0]      fill_q, fill_d;
   logic [FILL_W-1:0]      fill_eff, fill_inc;
   logic [LBP_SIZE-2:0]    hist_eff;
   logic                   le;
   logic                   first;

   // Compare bit: previous sample <= new sample, in the configured number format.
   generate
      if (SIGNED) begin : g_signed
         assign le = ($signed(last_q) <= $signed(sample_i));
      end else begin : g_unsigned
         assign le = (last_q <= sample_i);
      end
   endgenerate

   // Clear takes effect before a coincident sample, so the sample sees an empty window.
   always_comb begin
      fill_eff  = clear_i ? '0 : fill_q;
      hist_eff  = clear_i ? '0 : hist_q;
      first     = (fill_eff == '0);
      fill_inc  = (fill_eff >= FILL_MAX) ? FILL_MAX : fill_eff + FILL_W'(1);
      pattern_o = {hist_eff, le};
      emit_o    = (fill_inc >= FILL_MAX);
   end

   // Next-state: a write shifts the compare bit in; the very first sample only seeds last_q.
   always_comb begin
      last_d = last_q;
      hist_d = hist_eff;
      fill_d = fill_eff;
      if (we_i) begin
         last_d = sample_i;
         fill_d = fill_inc;
         hist_d = first ? '0 : pattern_o[LBP_SIZE-2:0];
      end
   end

   // Window state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= '0;
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         last_q <= last_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end
endmodule

module lbp_stream_extractor #(
   parameter int SAMPLE_SIZE  = 16,
   parameter int LBP_SIZE     = 6,
   parameter int NUM_CHANNELS = 4,
   parameter bit SIGNED       = 1'b0,
   parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CH_W-1:0]        in_ch,
   input  logic [SAMPLE_SIZE-1:0] sample_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CH_W-1:0]        out_ch,
   output logic [LBP_SIZE-1:0]    pattern
);
   localparam int             FILL_W = $clog2(LBP_SIZE + 2);
   localparam logic [CH_W:0]  NCH    = (CH_W + 1)'(NUM_CHANNELS);

   logic [NUM_CHANNELS-1:0][LBP_SIZE-1:0] slot_pat;
   logic [NUM_CHANNELS-1:0]               slot_emit;
   logic [NUM_CHANNELS-1:0]               slot_we;

   logic                accept, in_range, load;
   logic [LBP_SIZE-1:0] sel_pat;
   logic                sel_emit;

   logic                out_valid_q, out_valid_d;
   logic [CH_W-1:0]     out_ch_q, out_ch_d;
   logic [LBP_SIZE-1:0] pattern_q, pattern_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign in_range = ({1'b0, in_ch} < NCH);

   // One window slot per channel; only the addressed slot is written.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
         assign slot_we[gi] = accept && in_range && (in_ch == CH_W'(gi));
         lbp_ch_slot #(
            .SAMPLE_SIZE (SAMPLE_SIZE),
            .LBP_SIZE    (LBP_SIZE),
            .SIGNED      (SIGNED),
            .FILL_W      (FILL_W)
         ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .clear_i   (clear),
            .we_i      (slot_we[gi]),
            .sample_i  (sample_data),
            .pattern_o (slot_pat[gi]),
            .emit_o    (slot_emit[gi])
         );
      end
   endgenerate

   // Select the addressed slot by compare so out-of-range indices never index the arrays.
   always_comb begin
      sel_pat  = '0;
      sel_emit = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (in_ch == CH_W'(i)) begin
            sel_pat  = slot_pat[i];
            sel_emit = slot_emit[i];
         end
      end
   end

   assign load = accept && in_range && sel_emit;

   // Output register: drain on transfer, reload from the same cycle's accept with no bubble.
   always_comb begin
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      pattern_d   = pattern_q;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (load) begin
         out_valid_d = 1'b1;
         out_ch_d    = in_ch;
         pattern_d   = sel_pat;
      end
   end

   // Output holding register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         pattern_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         pattern_q   <= pattern_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign pattern   = pattern_q;
endmodule

// File: tb/tb_lbp_stream_extractor.sv
// Directed bench: an unsigned and a signed instance share one stimulus stream.
module tb_lbp_stream_extractor;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:0]  in_ch = 2'd0;
   logic [15:0] sample_data = 16'd0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid;
   logic [1:0]  out_ch;
   logic [5:0]  pattern;
   logic        in_ready_s, out_valid_s;
   logic [1:0]  out_ch_s;
   logic [5:0]  pattern_s;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lbp_stream_extractor #(.SIGNED(1'b0)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_ch(in_ch), .sample_data(sample_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch), .pattern(pattern));

   lbp_stream_extractor #(.SIGNED(1'b1)) dut_s (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_ch(in_ch), .sample_data(sample_data), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_ch(out_ch_s), .pattern(pattern_s));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One accepted sample; outputs are sampled 1 time unit after the edge.
   task automatic push(input logic [1:0] ch, input logic [15:0] d);
      in_valid = 1'b1; in_ch = ch; sample_data = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [5:0] pat, input logic [1:0] ch);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pat"},   32'(pattern),   32'(pat));
      chk({tag, "_ch"},    32'(out_ch),    32'(ch));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ramp [7];
      logic [15:0] ch1v [8];
      logic [15:0] clrv [7];
      logic [15:0] sgnv [7];
      ramp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
      ch1v = '{16'd1, 16'd3, 16'd2, 16'd4, 16'd4, 16'd0, 16'd9, 16'd5};
      clrv = '{16'd10, 16'd20, 16'd15, 16'd30, 16'd30, 16'd5, 16'd40};
      sgnv = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0001};

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pat",   32'(pattern),   32'd0);
      chk("rst_ch",    32'(out_ch),    32'd0);
      chk("rst_ready", 32'(in_ready),  32'd1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Ch0 ramp: six warm-up samples, seventh emits all ones
      for (int i = 0; i < 6; i++) begin
         push(2'd0, ramp[i]);
         chk("ramp_warm", 32'(out_valid), 32'd0);
      end
      push(2'd0, ramp[6]);
      chk_out("ramp", 6'b111111, 2'd0);

      // Ch1 mixed sequence, equality yields 1
      for (int i = 0; i < 6; i++) push(2'd1, ch1v[i]);
      chk("ch1_warm", 32'(out_valid), 32'd0);
      push(2'd1, ch1v[6]);
      chk_out("ch1_a", 6'b101101, 2'd1);
      push(2'd1, ch1v[7]);
      chk_out("ch1_b", 6'b011010, 2'd1);

      // Flush, then interleave ch0 descending and ch2 constant
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clr_drain", 32'(out_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         push(2'd0, 16'(7 - i));
         push(2'd2, 16'd5);
      end
      chk("ilv_warm", 32'(out_valid), 32'd0);
      push(2'd0, 16'd1);
      chk_out("ilv_ch0", 6'b000000, 2'd0);
      push(2'd2, 16'd5);
      chk_out("ilv_ch2", 6'b111111, 2'd2);

      // Stall: pending ch2 output held, pending ch0 sample not taken
      out_ready = 1'b0;
      in_valid = 1'b1; in_ch = 2'd0; sample_data = 16'd0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_rdy", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         chk_out("stall", 6'b111111, 2'd2);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_out("resume", 6'b000000, 2'd0);
      push(2'd0, 16'd5);
      chk_out("resume2", 6'b000001, 2'd0);

      // Clear does not drop a pending output
      out_ready = 1'b0;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk_out("clr_hold", 6'b000001, 2'd0);
      out_ready = 1'b1;

      // Clear coincident with a sample: that sample is the first of the window
      clear = 1'b1;
      push(2'd0, clrv[0]);
      clear = 1'b0;
      chk("clr_first", 32'(out_valid), 32'd0);
      for (int i = 1; i < 6; i++) begin
         push(2'd0, clrv[i]);
         chk("clr_warm", 32'(out_valid), 32'd0);
      end
      push(2'd0, clrv[6]);
      chk_out("clr_emit", 6'b101101, 2'd0);
      push(2'd0, 16'd50);
      chk_out("clr_next", 6'b011011, 2'd0);

      // Asynchronous reset in the middle of a stall
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_pat",   32'(pattern),   32'd0);
      chk("arst_ready", 32'(in_ready),  32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      push(2'd0, 16'd60);
      chk("arst_ch0", 32'(out_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         push(2'd1, 16'd3);
         chk("arst_warm", 32'(out_valid), 32'd0);
      end
      push(2'd1, 16'd3);
      chk_out("arst_emit", 6'b111111, 2'd1);

      // Signed vs unsigned compare on ch3
      for (int i = 0; i < 7; i++) push(2'd3, sgnv[i]);
      chk_out("uns", 6'b111110, 2'd3);
      chk("sgn_valid", 32'(out_valid_s), 32'd1);
      chk("sgn_pat",   32'(pattern_s),   32'(6'b111101));
      chk("sgn_ch",    32'(out_ch_s),    32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/lbp_stream_extractor.md
# lbp_stream_extractor

Streaming, multi-channel local-binary-pattern extractor for the EEG seizure-detection HDC front end. It accepts one sample per cycle, tagged with a channel index, and keeps per-channel sample history internally. Once a channel's window is full, it emits one LBP_SIZE-bit pattern for every new sample on that channel. It sits between the sample interface and the item-memory/encoder stage and replaces externally assembled sample windows with on-chip sliding windows, valid/ready flow control and an optional signed compare mode.

## Interface
- SAMPLE_SIZE, 16: sample width in bits.
- LBP_SIZE, 6: pattern width; each pattern spans LBP_SIZE+1 consecutive samples of one channel.
- NUM_CHANNELS, 4: number of independent channels.
- SIGNED, 0: 1 = compare samples as two's complement, 0 = unsigned.
- CH_W, $clog2(NUM_CHANNELS) (min 1): channel index width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- clear  in  1  synchronous flush of all channel histories.
- in_valid  in  1  sample_data/in_ch are valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_ch  in  CH_W  channel of the incoming sample.
- sample_data  in  SAMPLE_SIZE  incoming sample.
- out_valid  out  1  pattern/out_ch are valid.
- out_ready  in  1  downstream accepts the pattern.
- out_ch  out  CH_W  channel the pattern belongs to.
- pattern  out  LBP_SIZE  LBP code.

## Operation
- Accept: a sample is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (single output register, no combinational path from in_valid).
- Per-channel state: last sample (SAMPLE_SIZE), partial pattern history (LBP_SIZE-1 bits), fill count (saturates at LBP_SIZE+1).
- Compare bit for new sample x with previous sample p of the same channel: b = (p <= x), signed or unsigned per SIGNED.
- Pattern bit order: bit 0 = (x[n-1] <= x[n]); bit k = (x[n-1-k] <= x[n-k]). The MSB is the oldest pair. New pattern = {history[LBP_SIZE-2:0], b}.
- On accept: fill count increments (saturating), last sample ← x, history ← low LBP_SIZE-1 bits of new pattern.
- If the post-increment fill count is ≥ LBP_SIZE+1, the output register loads pattern and in_ch, and out_valid=1. Otherwise no output is produced (warm-up).
- First sample after reset or clear produces no compare bit; it only stores last sample.
- Channels are fully independent; arbitrary interleaving is legal.
- out_in_range: in_ch ≥ NUM_CHANNELS → sample accepted and discarded, no state change.
- clear: zeros all fill counts and histories; does not drop a pending output. If clear and an accepted sample occur in the same cycle, clear is applied first and the sample becomes the first sample of its channel.

## Timing
- Reset values: out_valid=0, pattern=0, out_ch=0, all fill counts/histories/last samples = 0. in_ready=1 after reset.
- Latency: accepted sample at edge t → pattern visible with out_valid=1 after edge t (1 cycle).
- Throughput: 1 pattern/cycle with out_ready held high.
- Backpressure: while out_valid && !out_ready, pattern/out_ch are held stable and in_ready=0.
- Output transfer and new accept can occur in the same cycle; the register reloads with no bubble.
- Async reset mid-warm-up or mid-stall: everything returns to reset values immediately; warm-up restarts.

## Test plan
- Ch0 samples 1,2,3,4,5,6,7 with out_ready=1 → no output for the first 6 samples; 7th → pattern=6'b111111, out_ch=0, one cycle later.
- Ch1 samples 1,3,2,4,4,0,9 then 5 → pattern 6'b101101, then 6'b011010. Equal values give 1.
- Interleave ch0 7,6,5,4,3,2,1 and ch2 5×7 alternately → ch0 6'b000000, ch2 6'b111111, each tagged correctly with no cross-talk.
- SIGNED=1, ch0 samples 0xFFFF, 0x0001, … → LSB of compare = 1. Same stimulus with SIGNED=0 → 0.
- Stall: hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0, pattern stable, no samples lost. Release → streaming resumes.
- Assert rst after 4 samples, or pulse clear → next 6 samples on that channel emit nothing and the 7th emits a pattern. Clear coincident with a sample → that sample counts as the first.
